// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   tx_state_t : frame sequencing states of the transmitter
//   LINE_IDLE  : level of the serial line between frames
//   START_LVL  : level of the start bit
//   STOP_LVL   : level of the stop bit(s)
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// ---------------------------------------------------------------------------
// tx_bit_timer
// Divides the system clock into serial bit periods. The count runs
// 0..BIT_PERIOD-1 while enabled and wraps; bit_tick marks the last cycle of
// each bit so the controller can move on to the next bit on that edge.
// Ports:
//   clk      in  system clock
//   n_rst    in  synchronous active-low reset
//   clear    in  hold the count at zero (controller idle)
//   enable   in  count this cycle
//   bit_tick out last cycle of the current bit period
// ---------------------------------------------------------------------------
module tx_bit_timer #(
   parameter int BIT_PERIOD = 10
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clear,
   input  logic enable,
   output logic bit_tick
);

   localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins, otherwise count up and wrap at the terminal count
   // so consecutive bits follow each other without a dead cycle.
   always_comb begin
      count_d  = count_q;
      bit_tick = enable && (count_q == LAST);
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         if (count_q == LAST) begin
            count_d = '0;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmitter. Takes one word per ready/valid handshake and sends it as
// start bit, data LSB-first, optional even parity bit, then stop bit(s).
// Ports:
//   clk        in  system clock, rising edge
//   n_rst      in  synchronous active-low reset
//   tx_data    in  word to send, captured on handshake
//   tx_valid   in  tx_data is valid
//   tx_ready   out accepting a word this cycle (idle only)
//   serial_out out registered serial line, idle high
//   tx_busy    out a frame is in progress
//   tx_done    out pulse in the final cycle of the last stop bit
// ---------------------------------------------------------------------------
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BIT_PERIOD = 10,
   parameter int PARITY_EN  = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 serial_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   tx_state_t state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IW-1:0] bit_idx_q, bit_idx_d;
   logic parity_q, parity_d;
   logic stop_idx_q, stop_idx_d;
   logic serial_q, serial_d;
   logic bit_tick;
   logic last_stop;

   // The timer only runs while a frame is on the line, so every frame starts
   // with a fresh, full-length start bit.
   tx_bit_timer #(
      .BIT_PERIOD(BIT_PERIOD)
   ) u_timer (
      .clk     (clk),
      .n_rst   (n_rst),
      .clear   (state_q == IDLE),
      .enable  (state_q != IDLE),
      .bit_tick(bit_tick)
   );

   assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;

   // Frame sequencing. The shift register moves right at each data bit
   // boundary so its LSB is always the bit on the line. tx_done is raised
   // on the tick that ends the last stop bit, i.e. its final cycle.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      tx_done    = 1'b0;
      case (state_q)
         IDLE: begin
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            if (tx_valid) begin
               shift_d  = tx_data;
               parity_d = ^tx_data;
               state_d  = START;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + IW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               if (last_stop) begin
                  tx_done = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The line level is decoded from where the frame will be next cycle, so
   // the registered output lines up exactly with the state it belongs to.
   always_comb begin
      serial_d = LINE_IDLE;
      case (state_d)
         IDLE:    serial_d = LINE_IDLE;
         START:   serial_d = START_LVL;
         DATA:    serial_d = shift_d[0];
         PARITY:  serial_d = parity_d;
         STOP:    serial_d = STOP_LVL;
         default: serial_d = LINE_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any frame and drives the
   // line back to idle on the same edge.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         serial_q   <= LINE_IDLE;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         serial_q   <= serial_d;
      end
   end

   assign tx_ready   = (state_q == IDLE);
   assign tx_busy    = (state_q != IDLE);
   assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Three transmitters: default framing, even parity, and two stop bits.
// Stimulus pushes hand-written expected frames (slot k = line level of bit
// slot k, slot 0 being the start bit) into a per-instance queue; a monitor
// per instance pops on each handshake it observes and checks every cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

   localparam int BP = 10;

   typedef struct {
      logic [15:0] slots;
      int          nSlots;
      int          abortAt;
   } frame_t;

   logic       clk;
   logic       nRst;
   logic [2:0] txValid;
   logic [7:0] txData [3];
   wire  [2:0] ready;
   wire  [2:0] serOut;
   wire  [2:0] busy;
   wire  [2:0] done;

   frame_t q0[$];
   frame_t q1[$];
   frame_t q2[$];

   int cmpCount  = 0;
   int failCount = 0;
   bit monEn     = 1'b0;

   uart_tx_ctrl #(.DATA_BITS(8), .BIT_PERIOD(BP), .PARITY_EN(0), .STOP_BITS(1)) dutPlain (
      .clk(clk), .n_rst(nRst), .tx_data(txData[0]), .tx_valid(txValid[0]),
      .tx_ready(ready[0]), .serial_out(serOut[0]), .tx_busy(busy[0]), .tx_done(done[0]));

   uart_tx_ctrl #(.DATA_BITS(8), .BIT_PERIOD(BP), .PARITY_EN(1), .STOP_BITS(1)) dutParity (
      .clk(clk), .n_rst(nRst), .tx_data(txData[1]), .tx_valid(txValid[1]),
      .tx_ready(ready[1]), .serial_out(serOut[1]), .tx_busy(busy[1]), .tx_done(done[1]));

   uart_tx_ctrl #(.DATA_BITS(8), .BIT_PERIOD(BP), .PARITY_EN(0), .STOP_BITS(2)) dutStop2 (
      .clk(clk), .n_rst(nRst), .tx_data(txData[2]), .tx_valid(txValid[2]),
      .tx_ready(ready[2]), .serial_out(serOut[2]), .tx_busy(busy[2]), .tx_done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare {serial_out, tx_done, tx_ready, tx_busy} of one instance.
   task automatic checkOutput(input int idx, input string tag, input int cyc,
                              input logic [3:0] expVal);
      logic [3:0] got;
      got = {serOut[idx], done[idx], ready[idx], busy[idx]};
      cmpCount++;
      if (got !== expVal) begin
         failCount++;
         $display("[TB] FAIL inst%0d %s cycle %0d: ser/done/rdy/busy got %b required %b",
                  idx, tag, cyc, got, expVal);
      end
   endtask

   task automatic pushFrame(input int idx, input frame_t f);
      case (idx)
         0: q0.push_back(f);
         1: q1.push_back(f);
         default: q2.push_back(f);
      endcase
   endtask

   task automatic popFrame(input int idx, output frame_t f, output bit ok);
      ok = 1'b1;
      f  = '{slots: '0, nSlots: 0, abortAt: 0};
      case (idx)
         0: if (q0.size() > 0) f = q0.pop_front(); else ok = 1'b0;
         1: if (q1.size() > 0) f = q1.pop_front(); else ok = 1'b0;
         default: if (q2.size() > 0) f = q2.pop_front(); else ok = 1'b0;
      endcase
   endtask

   // Monitor: idle cycles must look idle; a handshake starts a frame whose
   // every cycle is compared against the popped expectation.
   task automatic monitorInst(input int idx);
      frame_t f;
      bit     ok;
      int     len;
      forever begin
         @(negedge clk);
         if (monEn) begin
            checkOutput(idx, "idle", 0, 4'b1010);
            if (txValid[idx] && ready[idx] && nRst) begin
               popFrame(idx, f, ok);
               cmpCount++;
               if (!ok) begin
                  failCount++;
                  $display("[TB] FAIL inst%0d unexpected capture: got handshake required none", idx);
               end else begin
                  len = f.nSlots * BP;
                  for (int k = 1; k <= len; k++) begin
                     @(negedge clk);
                     if (f.abortAt != 0 && k == f.abortAt) begin
                        checkOutput(idx, "reset", k, 4'b1010);
                        break;
                     end
                     checkOutput(idx, "frame", k,
                                 {f.slots[(k - 1) / BP], (k == len), 1'b0, 1'b1});
                  end
               end
            end
         end
      end
   endtask

   initial monitorInst(0);
   initial monitorInst(1);
   initial monitorInst(2);

   // Wait (bounded) for the instance to be ready, then let the edge capture.
   task automatic waitHandshake(input int idx);
      int t = 0;
      @(negedge clk);
      while (!ready[idx] && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!ready[idx]) begin
         cmpCount++;
         failCount++;
         $display("[TB] FAIL inst%0d handshake timeout: got ready=0 required ready=1", idx);
      end
      @(posedge clk);
      #1;
   endtask

   // Push the expected frame and drive one handshake; returns in cycle N+1.
   task automatic applyStimulus(input int idx, input logic [7:0] data,
                                input logic [15:0] slots, input int nSlots,
                                input int abortAt);
      pushFrame(idx, '{slots: slots, nSlots: nSlots, abortAt: abortAt});
      txData[idx]  = data;
      txValid[idx] = 1'b1;
      waitHandshake(idx);
      txValid[idx] = 1'b0;
   endtask

   task automatic waitIdle(input int idx);
      int t = 0;
      @(negedge clk);
      while (!ready[idx] && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!ready[idx]) begin
         cmpCount++;
         failCount++;
         $display("[TB] FAIL inst%0d idle timeout: got ready=0 required ready=1", idx);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no end of test required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nRst    = 1'b0;
      txValid = '0;
      for (int i = 0; i < 3; i++) txData[i] = 8'h00;
      @(posedge clk);
      #1;
      monEn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nRst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] basic frames, default framing");
      applyStimulus(0, 8'hA5, 16'(10'b1_10100101_0), 10, 0);
      waitIdle(0);
      applyStimulus(0, 8'h00, 16'(10'b1_00000000_0), 10, 0);
      waitIdle(0);
      applyStimulus(0, 8'hFF, 16'(10'b1_11111111_0), 10, 0);
      waitIdle(0);

      $display("[TB] busy ignore");
      applyStimulus(0, 8'hA5, 16'(10'b1_10100101_0), 10, 0);
      repeat (4) @(posedge clk);
      #1;
      txData[0]  = 8'h3C;
      txValid[0] = 1'b1;
      repeat (46) @(posedge clk);
      #1;
      txValid[0] = 1'b0;
      txData[0]  = 8'h00;
      waitIdle(0);

      $display("[TB] back-to-back");
      pushFrame(0, '{slots: 16'(10'b1_01010101_0), nSlots: 10, abortAt: 0});
      txData[0]  = 8'h55;
      txValid[0] = 1'b1;
      waitHandshake(0);
      pushFrame(0, '{slots: 16'(10'b1_00001111_0), nSlots: 10, abortAt: 0});
      txData[0] = 8'h0F;
      waitHandshake(0);
      txValid[0] = 1'b0;
      waitIdle(0);

      $display("[TB] even parity");
      applyStimulus(1, 8'h07, 16'(11'b1_1_00000111_0), 11, 0);
      waitIdle(1);
      applyStimulus(1, 8'h03, 16'(11'b1_0_00000011_0), 11, 0);
      waitIdle(1);

      $display("[TB] two stop bits");
      applyStimulus(2, 8'hFF, 16'(11'b11_11111111_0), 11, 0);
      waitIdle(2);
      applyStimulus(2, 8'h81, 16'(11'b11_10000001_0), 11, 0);
      waitIdle(2);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 8'hC3, 16'(10'b1_11000011_0), 10, 45);
      repeat (43) @(posedge clk);
      #1;
      nRst = 1'b0;
      @(posedge clk);
      #1;
      nRst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      applyStimulus(0, 8'h3C, 16'(10'b1_00111100_0), 10, 0);
      waitIdle(0);

      repeat (5) @(posedge clk);
      cmpCount++;
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard drain: got %0d frames pending required 0",
                  q0.size() + q1.size() + q2.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmitter: the transmit-side counterpart of the team's UART receive path.
- Accepts one parallel byte per ready/valid handshake and serialises it onto serial_out as a UART frame: start bit, data LSB-first, optional even parity, then stop bit(s).
- Line encoding is identical to what the receive path expects: idle high, start low, stop high, BIT_PERIOD clocks per bit.
- Sits between the host-side data source and the pad driving the serial line.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- BIT_PERIOD, 10, clock cycles per serial bit (>=2).
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- n_rst  input  1  reset, synchronous, active-low (sampled on rising clk).
- tx_data  input  DATA_BITS  byte to transmit, captured on handshake.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a byte this cycle.
- serial_out  output  1  serial line, registered, idle high.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (n_rst=0 at a clk edge): state=IDLE; counters and shift register cleared; serial_out=1, tx_busy=0, tx_done=0. tx_ready=1 from the first cycle after reset.
- Reset mid-frame: the frame is abandoned, the line returns high at that edge, and no tx_done is produced.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - serial_out=1, tx_ready=1, tx_busy=0.
  - Handshake (tx_valid & tx_ready) in cycle N: tx_data is latched into the shift register, parity is computed as the XOR of the data bits, and the next state is START.
- START: serial_out=0 for cycles N+1..N+BIT_PERIOD.
- DATA:
  - Bit i (LSB first) is driven for BIT_PERIOD cycles.
  - The shift register shifts right at each bit boundary.
  - A bit index counter tracks i from 0 to DATA_BITS-1.
- PARITY (only when PARITY_EN=1): drives the parity bit for BIT_PERIOD cycles. When PARITY_EN=0 the DATA state goes straight to STOP.
- STOP:
  - serial_out=1 for STOP_BITS*BIT_PERIOD cycles.
  - tx_done=1 in the last of those cycles, then the next state is IDLE.
- Bit timer:
  - Counter of width $clog2(BIT_PERIOD) runs 0..BIT_PERIOD-1 and wraps to 0.
  - Its terminal count advances the bit/state.
  - Cleared in IDLE.
- serial_out is driven from a flop: next value decoded from next state and shift register LSB, so there are no combinational glitches.
- tx_ready is high only in IDLE, so it is low from cycle N+1 until the frame ends.
- tx_busy is high in every non-IDLE state.
- tx_valid and tx_data changes while busy are ignored.
- Total line occupancy per frame is (1+DATA_BITS+PARITY_EN+STOP_BITS)*BIT_PERIOD cycles. At least 1 IDLE cycle separates frames.
- tx_valid held high continuously produces back-to-back frames, each accepted in the single IDLE cycle after the previous tx_done.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
- Sub-module tx_bit_timer, parameter BIT_PERIOD:
  - ports: clk, n_rst, clear, enable, bit_tick;
  - bit_tick=1 when the count equals BIT_PERIOD-1 while enabled.
- FSM, shift register, parity and output flop stay in uart_tx_ctrl.

Test Plan:
- Default params; send 0xA5, handshake at cycle N.
  - serial_out=0 over N+1..N+10.
  - Data bits 1,0,1,0,0,1,0,1 in 10-cycle slots from N+11.
  - serial_out=1 over N+91..N+100; tx_done=1 only at N+100; tx_ready=1 at N+101.
- PARITY_EN=1; send 0x07 → parity slot (cycles N+91..N+100) =1, stop over N+101..N+110, tx_done at N+110. Send 0x03 → parity slot =0.
- STOP_BITS=2; send 0xFF → line high N+91..N+110, tx_done at N+110 only.
- Busy-ignore: drive tx_valid=1 with tx_data=0x3C during cycles N+5..N+50 of a 0xA5 frame → no capture, tx_ready=0 throughout, and the 0xA5 waveform is unchanged.
- Back-to-back: tx_valid held high with 0x55 then 0x0F → the second start bit begins at N+102, and exactly one IDLE-high cycle (N+101) separates the frames.
- Reset mid-frame: assert n_rst=0 at cycle N+45 of a frame → at that edge serial_out=1, tx_busy=0, tx_ready=1; no tx_done ever appears. A new byte sent after release gives a correct full frame.
